// File: rtl/cordic_iter_seq.sv
// Iterative CORDIC rotation-mode sequencer.
// One shared micro-rotation datapath is reused once per clock for ITER
// iterations. The operand set enters through a valid/ready handshake and the
// result is held in DONE until the consumer takes it.
// ITER must lie in 1..8 because the shift index is 3 bits wide.
module cordic_iter_seq #(
  parameter int ITER = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] in_x,
  input  logic [18:0] in_y,
  input  logic [8:0]  in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] out_x,
  output logic [18:0] out_y,
  output logic [8:0]  out_z,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_I = 3'(ITER - 1);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic signed [18:0] x_q, x_d;
  logic signed [18:0] y_q, y_d;
  logic signed [8:0]  z_q, z_d;

  logic signed [8:0]  z_in_s;
  logic signed [8:0]  z_clamped;
  logic signed [18:0] x_sh;
  logic signed [18:0] y_sh;
  logic signed [8:0]  atan_c;

  // Arctangent of 2^-i in half-degree codes, indexed by the iteration counter.
  always_comb begin
    atan_c = 9'sd0;
    case (cnt_q)
      3'd0:    atan_c = 9'sd90;
      3'd1:    atan_c = 9'sd53;
      3'd2:    atan_c = 9'sd28;
      3'd3:    atan_c = 9'sd14;
      3'd4:    atan_c = 9'sd7;
      3'd5:    atan_c = 9'sd4;
      3'd6:    atan_c = 9'sd2;
      default: atan_c = 9'sd1;
    endcase
  end

  // Limit the requested angle to +/-90 degrees so the rotation converges.
  always_comb begin
    z_in_s    = $signed(in_z);
    z_clamped = z_in_s;
    if (z_in_s > 9'sd180) begin
      z_clamped = 9'sd180;
    end else if (z_in_s < -9'sd180) begin
      z_clamped = -9'sd180;
    end
  end

  // Both cross terms come from the pre-update x and y (sign-preserving shifts).
  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
  end

  // Next-state, counter and datapath update for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = $signed(in_x);
          y_d     = $signed(in_y);
          z_d     = z_clamped;
          cnt_d   = 3'd0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        // Zero residual angle rotates in the positive direction.
        if (z_q[8]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_c;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_I) begin
          cnt_d   = 3'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      x_q     <= 19'sd0;
      y_q     <= 19'sd0;
      z_q     <= 9'sd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  // Handshake flags decode only the registered state, so no input reaches
  // them combinationally. The working registers double as result registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_x     = x_q;
    out_y     = y_q;
    out_z     = z_q;
  end

endmodule

// File: doc/cordic_iter_seq.md
Name: cordic_iter_seq

Overview:
Iterative CORDIC rotation-mode sequencer. It accepts a vector (x, y) and an angle z, and runs ITER micro-rotations through one shared single-iteration datapath, one iteration per clock. Each iteration supplies shift index i and the matching arctangent constant. The block feeds the single-iteration CORDIC unit and wraps it with input/output valid-ready handshakes, so the angle/vector front end and the downstream consumer see a streaming interface.

Parameters:
ITER, 8, number of micro-rotations per operation; legal range 1..8 (shift index is 3 bits).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request carries a valid operand set.
in_ready  output  1  block can accept an operand set.
in_x  input  19  signed initial x; Q2.16, pre-scaled by K = 0.60725 by the caller.
in_y  input  19  signed initial y; Q2.16.
in_z  input  9  signed target angle; LSB = 0.5 degree.
out_valid  output  1  result registers hold a finished result.
out_ready  input  1  consumer accepts the result.
out_x  output  19  signed rotated x.
out_y  output  19  signed rotated y.
out_z  output  9  signed residual angle after the final iteration.
busy  output  1  high in ROTATE and DONE.

Behaviour:
- Reset: asynchronous, active-low, on rst_n low.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_x/out_y/out_z=0.
  - Internal: state=IDLE, iteration counter=0.
  - Reset asserted mid-operation aborts the operation immediately. No output handshake occurs.
- States: IDLE, ROTATE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a clock edge: load x=in_x, y=in_y, z=clamp(in_z), counter=0, then go to ROTATE.
- ROTATE:
  - One micro-rotation per edge, using shift i=counter.
  - If z[8]=1 (negative): x'=x+(y>>>i), y'=y-(x>>>i), z'=z+atan[i].
  - Else (z>=0; zero counts as positive): x'=x-(y>>>i), y'=y+(x>>>i), z'=z-atan[i].
  - Shifts are arithmetic (sign-preserving). Both shifts use the pre-update x and y.
  - Adds are 19-bit and 9-bit two's-complement. No saturation; overflow wraps.
  - The counter increments each edge. On the edge that applies i=ITER-1, go to DONE and set out_valid=1.
- atan ROM (in 0.5-degree codes), i=0..7: 90, 53, 28, 14, 7, 4, 2, 1. Fixed constants, not a parameter.
- Clamp: in_z > +180 loads +180; in_z < -180 loads -180. This range is ±90 degrees, inside CORDIC convergence.
- Input range contract: caller keeps |in_x|,|in_y| <= 2^17. Results outside this contract wrap and are not checked.
- DONE:
  - out_valid=1, with out_x/out_y/out_z stable.
  - On out_ready, go to IDLE at the same edge, clearing out_valid. in_ready=1 from the next cycle.
  - Holding out_ready low holds DONE indefinitely, with outputs unchanged.
- Latency: acceptance edge T gives out_valid high after edge T+ITER. With out_ready tied high, the next acceptance is possible at edge T+ITER+2.
- in_ready=0 in ROTATE and DONE. in_valid is ignored there, and in_x/in_y/in_z may change freely.
- out_valid=0 in IDLE and ROTATE.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
1. Reset and idle.
   - Stimulus: rst_n low, then high; in_valid=0 for 5 cycles.
   - Required: in_ready=1, out_valid=0, busy=0, all outputs 0.
2. Rotation by 30 degrees.
   - Stimulus: in_x=39797, in_y=0, in_z=60, out_ready=1.
   - Required: out_valid exactly 8 cycles after accept.
   - Required: out_x and out_y bit-exact to the team golden model; within ±1400 LSB of 56756 and 32768; |out_z| <= 1.
3. Negative angle and clamp.
   - Stimulus: in_z=-200, in_x=39797, in_y=0.
   - Required: operation runs as in_z=-180; out_x ~ 0 (±1400), out_y ~ -65536 (±1400).
4. Output backpressure.
   - Stimulus: hold out_ready=0 for 20 cycles after out_valid; toggle in_valid with new data during that time.
   - Required: outputs unchanged, in_ready=0, no second operation starts.
   - Required: out_ready=1 for one cycle, then in_ready=1 on the next cycle.
5. Reset mid-operation.
   - Stimulus: assert rst_n low at iteration 4, release, then issue a new operation.
   - Required: out_valid never asserts for the aborted op; the new op's result is bit-exact.
6. Back-to-back operations.
   - Stimulus: 50 random ops with in_z in [-180,180] and |in_x|,|in_y| <= 2^17, random out_ready stalls.
   - Required: every result is bit-exact to the model; no lost or duplicated result; ITER=4 run repeats the check with latency 4.
